// File: rtl/note_recorder_pkg.sv
// Shared definitions for the note recorder: FSM states and buffer entry layout.
// An entry is {notes[7:0], shift[1:0], dur[DUR_W-1:0]}, with dur in the low bits.
package note_recorder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_RECORD     = 2'd1,
    ST_PLAY_FETCH = 2'd2,
    ST_PLAY_HOLD  = 2'd3
  } state_e;

  localparam int NOTE_W  = 8;
  localparam int SHIFT_W = 2;
  localparam int KEY_W   = NOTE_W + SHIFT_W;

  // Total entry width for a given duration field width.
  function automatic int entry_w(input int dur_w);
    return KEY_W + dur_w;
  endfunction

  // Bit position of the shift field inside an entry.
  function automatic int shift_lsb(input int dur_w);
    return dur_w;
  endfunction

  // Bit position of the notes field inside an entry.
  function automatic int notes_lsb(input int dur_w);
    return dur_w + SHIFT_W;
  endfunction

endpackage

// File: rtl/note_recorder_tick_gen.sv
// Duration tick generator: one-clock pulse every CLK_HZ/TICK_HZ clocks.
// A synchronous clear restarts the count so the first tick lands a full
// period after a record or playback start.
module note_recorder_tick_gen #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int DIV   = (CLK_HZ / TICK_HZ > 1) ? CLK_HZ / TICK_HZ : 2;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // Free-running divider, wrapping at DIV-1, restarted by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  assign tick = (cnt_r == CNT_LAST);

endmodule

// File: rtl/note_recorder.sv
// Note recorder: passes live keys to the sound block, records key patterns
// with tick-resolution durations, and replays them with the recorded timing.
module note_recorder
  import note_recorder_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100,
  parameter int DEPTH   = 64,
  parameter int DUR_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               keys,
  input  logic [1:0]               key_shift,
  input  logic                     rec_start,
  input  logic                     play_start,
  input  logic                     stop,
  output logic [7:0]               notes,
  output logic [1:0]               shift,
  output logic                     recording,
  output logic                     playing,
  output logic                     full,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   length
);

  localparam int ADDR_W    = $clog2(DEPTH);
  localparam int LEN_W     = ADDR_W + 1;
  localparam int ENTRY_W   = entry_w(DUR_W);
  localparam int SHIFT_LSB = shift_lsb(DUR_W);
  localparam int NOTES_LSB = notes_lsb(DUR_W);

  localparam logic [LEN_W-1:0]  LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0]  LEN_LAST = LEN_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
  localparam logic [DUR_W-1:0]  DUR_ZERO = {DUR_W{1'b0}};
  localparam logic [DUR_W-1:0]  DUR_ONE  = DUR_W'(1);
  localparam logic [DUR_W-1:0]  DUR_MAX  = {DUR_W{1'b1}};

  state_e              state_r;
  logic [KEY_W-1:0]    cur_r;
  logic [DUR_W-1:0]    dur_r;
  logic [DUR_W-1:0]    remain_r;
  logic [ADDR_W-1:0]   idx_r;
  logic [ENTRY_W-1:0]  mem_r [DEPTH];

  logic [KEY_W-1:0]    key_s;
  logic [ENTRY_W-1:0]  rd_entry_s;
  logic [LEN_W-1:0]    last_idx_s;
  logic                key_chg_s;
  logic                dur_sat_s;
  logic                tick_s;
  logic                tick_clr_s;
  logic                rec_write_s;

  assign key_s      = {keys, key_shift};
  assign rd_entry_s = mem_r[idx_r];
  assign last_idx_s = length - LEN_ONE;
  assign key_chg_s  = (key_s != cur_r);
  assign dur_sat_s  = (dur_r == DUR_MAX);

  note_recorder_tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tick_clr_s),
    .tick  (tick_s)
  );

  // Restart the tick divider whenever a record or playback start is accepted.
  always_comb begin
    tick_clr_s = 1'b0;
    if ((state_r == ST_IDLE) && !stop && (rec_start || play_start)) begin
      tick_clr_s = 1'b1;
    end else begin
      tick_clr_s = 1'b0;
    end
  end

  // Buffer write: flush on stop, or on a tick that closes the current pair;
  // a pair with zero duration is never written.
  always_comb begin
    rec_write_s = 1'b0;
    if ((state_r == ST_RECORD) && (dur_r != DUR_ZERO)) begin
      if (stop) begin
        rec_write_s = 1'b1;
      end else if (tick_s && (key_chg_s || dur_sat_s)) begin
        rec_write_s = 1'b1;
      end else begin
        rec_write_s = 1'b0;
      end
    end else begin
      rec_write_s = 1'b0;
    end
  end

  // Entry storage; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (rec_write_s) begin
      mem_r[length[ADDR_W-1:0]] <= {cur_r, dur_r};
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      notes     <= 8'h00;
      shift     <= 2'd0;
      recording <= 1'b0;
      playing   <= 1'b0;
      full      <= 1'b0;
      done      <= 1'b0;
      length    <= LEN_ZERO;
      cur_r     <= {KEY_W{1'b0}};
      dur_r     <= DUR_ZERO;
      remain_r  <= DUR_ZERO;
      idx_r     <= {ADDR_W{1'b0}};
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          notes <= keys;
          shift <= key_shift;
          if (stop) begin
            state_r <= ST_IDLE;
          end else if (rec_start) begin
            state_r   <= ST_RECORD;
            recording <= 1'b1;
            length    <= LEN_ZERO;
            full      <= 1'b0;
            cur_r     <= key_s;
            dur_r     <= DUR_ZERO;
          end else if (play_start) begin
            if (length == LEN_ZERO) begin
              done <= 1'b1;
            end else begin
              idx_r   <= {ADDR_W{1'b0}};
              state_r <= ST_PLAY_FETCH;
              playing <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_RECORD: begin
          notes <= keys;
          shift <= key_shift;
          if (rec_write_s) begin
            length <= length + LEN_ONE;
          end
          if (stop) begin
            if (rec_write_s && (length == LEN_LAST)) begin
              full <= 1'b1;
            end
            state_r   <= ST_IDLE;
            recording <= 1'b0;
          end else if (tick_s) begin
            if (key_chg_s || dur_sat_s) begin
              cur_r <= key_s;
              dur_r <= DUR_ONE;
              if (rec_write_s && (length == LEN_LAST)) begin
                full      <= 1'b1;
                state_r   <= ST_IDLE;
                recording <= 1'b0;
              end
            end else begin
              dur_r <= dur_r + DUR_ONE;
            end
          end else begin
            state_r <= ST_RECORD;
          end
        end

        ST_PLAY_FETCH: begin
          if (stop) begin
            notes   <= 8'h00;
            shift   <= 2'd0;
            done    <= 1'b1;
            playing <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            notes    <= rd_entry_s[NOTES_LSB +: NOTE_W];
            shift    <= rd_entry_s[SHIFT_LSB +: SHIFT_W];
            remain_r <= rd_entry_s[DUR_W-1:0];
            state_r  <= ST_PLAY_HOLD;
          end
        end

        ST_PLAY_HOLD: begin
          if (stop) begin
            notes   <= 8'h00;
            shift   <= 2'd0;
            done    <= 1'b1;
            playing <= 1'b0;
            state_r <= ST_IDLE;
          end else if (tick_s) begin
            if (remain_r <= DUR_ONE) begin
              if ({1'b0, idx_r} == last_idx_s) begin
                notes   <= 8'h00;
                shift   <= 2'd0;
                done    <= 1'b1;
                playing <= 1'b0;
                state_r <= ST_IDLE;
              end else begin
                idx_r   <= idx_r + IDX_ONE;
                state_r <= ST_PLAY_FETCH;
              end
            end else begin
              remain_r <= remain_r - DUR_ONE;
            end
          end else begin
            state_r <= ST_PLAY_HOLD;
          end
        end

        default: begin
          state_r   <= ST_IDLE;
          recording <= 1'b0;
          playing   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder: 10 clk per tick, 4 entries, 3-bit durations.
module tb_note_recorder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] keys;
  logic [1:0] key_shift;
  logic       rec_start;
  logic       play_start;
  logic       stop;
  logic [7:0] notes;
  logic [1:0] shift;
  logic       recording;
  logic       playing;
  logic       full;
  logic       done;
  logic [2:0] length;

  int n_checks = 0;
  int n_pass   = 0;

  logic [12:0] exp_entry;

  note_recorder #(
    .CLK_HZ  (1000),
    .TICK_HZ (100),
    .DEPTH   (4),
    .DUR_W   (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .keys       (keys),
    .key_shift  (key_shift),
    .rec_start  (rec_start),
    .play_start (play_start),
    .stop       (stop),
    .notes      (notes),
    .shift      (shift),
    .recording  (recording),
    .playing    (playing),
    .full       (full),
    .done       (done),
    .length     (length)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0; keys = 8'h00; key_shift = 2'd0;
    rec_start = 1'b0; play_start = 1'b0; stop = 1'b0;
    step(2);
    chk("rst_notes", notes, 32'h0);
    chk("rst_len", length, 32'h0);
    chk("rst_flags", {recording, playing, full, done}, 32'h0);
    rst_n = 1'b1;

    // 1. idle pass-through
    keys = 8'h05; key_shift = 2'd2;
    step(1);
    chk("idle_notes", notes, 32'h05);
    chk("idle_shift", shift, 32'h2);
    chk("idle_flags", {recording, playing, full, done}, 32'h0);

    // 2. record 01 x3 ticks, 04 x2 ticks, then replay
    keys = 8'h01; key_shift = 2'd0;
    rec_start = 1'b1; step(1); rec_start = 1'b0;
    chk("rec_on", recording, 32'h1);
    chk("rec_pass", notes, 32'h01);
    step(34); keys = 8'h04;
    step(20); stop = 1'b1; step(1); stop = 1'b0;
    chk("rec2_len", length, 32'h2);
    chk("rec2_off", recording, 32'h0);
    keys = 8'hFF;
    play_start = 1'b1; step(1); play_start = 1'b0;
    chk("play_on", playing, 32'h1);
    chk("play_p0", notes, 32'hFF);
    step(1);  chk("play_e0_first", notes, 32'h01);
    step(24); chk("play_e0_mid", notes, 32'h01);
    step(5);  chk("play_e0_last", notes, 32'h01);
    step(1);  chk("play_e1_first", notes, 32'h04);
    step(14); chk("play_e1_last", notes, 32'h04);
    chk("play_no_early_done", done, 32'h0);
    step(5);
    chk("play_end_notes", notes, 32'h00);
    chk("play_end_done", done, 32'h1);
    chk("play_end_off", playing, 32'h0);
    step(1);
    chk("play_done_pulse", done, 32'h0);
    chk("play_len_kept", length, 32'h2);

    // 5a. stop during entry 0 of a repeated playback
    play_start = 1'b1; step(1); play_start = 1'b0;
    step(5); chk("replay_e0", notes, 32'h01);
    stop = 1'b1; step(1); stop = 1'b0;
    chk("stop_notes", notes, 32'h00);
    chk("stop_done", done, 32'h1);
    chk("stop_off", playing, 32'h0);
    step(1); chk("stop_done_pulse", done, 32'h0);

    // 3. duration saturation: 02 held for 10 ticks
    keys = 8'h02;
    rec_start = 1'b1; step(1); rec_start = 1'b0;
    step(104); stop = 1'b1; step(1); stop = 1'b0;
    chk("sat_len", length, 32'h2);
    exp_entry = {8'h02, 2'd0, 3'd7};
    chk("sat_e0", dut.mem_r[0], exp_entry);
    exp_entry = {8'h02, 2'd0, 3'd3};
    chk("sat_e1", dut.mem_r[1], exp_entry);

    // 4. buffer full with 5 one-tick patterns
    keys = 8'h11;
    rec_start = 1'b1; step(1); rec_start = 1'b0;
    step(15); keys = 8'h22;
    step(10); keys = 8'h33;
    step(10); keys = 8'h44;
    step(10); keys = 8'h55;
    step(4);
    chk("full_pre_len", length, 32'h3);
    chk("full_pre_flag", {recording, full}, 32'h2);
    step(1);
    chk("full_flag", full, 32'h1);
    chk("full_rec_off", recording, 32'h0);
    chk("full_len", length, 32'h4);
    exp_entry = {8'h44, 2'd0, 3'd1};
    chk("full_e3", dut.mem_r[3], exp_entry);
    step(10);
    chk("full_len_hold", length, 32'h4);

    // 5b. empty recording, then empty play
    rec_start = 1'b1; step(1); rec_start = 1'b0;
    chk("rec_clr_full", full, 32'h0);
    stop = 1'b1; step(1); stop = 1'b0;
    chk("empty_len", length, 32'h0);
    keys = 8'h3C;
    play_start = 1'b1; step(1); play_start = 1'b0;
    chk("empty_done", done, 32'h1);
    chk("empty_noplay", playing, 32'h0);
    chk("empty_notes", notes, 32'h3C);
    step(1);
    chk("empty_done_pulse", done, 32'h0);
    chk("empty_noplay2", playing, 32'h0);

    // 6. stop beats rec_start during play
    keys = 8'h21;
    rec_start = 1'b1; step(1); rec_start = 1'b0;
    step(14); stop = 1'b1; step(1); stop = 1'b0;
    chk("p6_len", length, 32'h1);
    play_start = 1'b1; step(1); play_start = 1'b0;
    step(3); chk("p6_playing", notes, 32'h21);
    rec_start = 1'b1; stop = 1'b1; step(1); rec_start = 1'b0; stop = 1'b0;
    chk("prio_done", done, 32'h1);
    chk("prio_flags", {recording, playing}, 32'h0);
    chk("prio_notes", notes, 32'h00);
    step(1);
    chk("prio_no_rec", recording, 32'h0);

    // 6b. asynchronous reset mid-play
    play_start = 1'b1; step(1); play_start = 1'b0;
    step(3);
    rst_n = 1'b0; #1;
    chk("arst_notes", notes, 32'h00);
    chk("arst_playing", playing, 32'h0);
    chk("arst_len", length, 32'h0);
    step(1); rst_n = 1'b1; step(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
